// File: rtl/perceptron_sequencer.sv
// Streaming front/back-end for a pipelined perceptron core: gathers N activations,
// hands the core a stable x/w/b snapshot, waits out its latency and returns y.
module perceptron_sequencer #(
    parameter int N          = 4,
    parameter int DATA_WIDTH = 8,
    parameter int LATENCY    = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         w_wr_en,
    input  logic [$clog2(N)-1:0]         w_wr_idx,
    input  logic signed [DATA_WIDTH-1:0] w_wr_data,
    input  logic                         b_wr_en,
    input  logic signed [DATA_WIDTH-1:0] b_wr_data,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    output logic [N*DATA_WIDTH-1:0]      pe_x,
    output logic [N*DATA_WIDTH-1:0]      pe_w,
    output logic signed [DATA_WIDTH-1:0] pe_b,
    input  logic signed [DATA_WIDTH-1:0] pe_y,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_WIDTH-1:0] out_data,
    output logic                         busy
);

    localparam int IDX_W = $clog2(N);
    localparam int CNT_W = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        WAIT   = 2'd1,
        RESULT = 2'd2
    } state_t;

    state_t                         state;
    state_t                         state_next;
    logic [IDX_W-1:0]               count;
    logic [CNT_W-1:0]               lat_cnt;
    logic signed [DATA_WIDTH-1:0]   w_bank [N];
    logic signed [DATA_WIDTH-1:0]   b_reg;
    logic [N*DATA_WIDTH-1:0]        w_packed;
    logic                           accept;
    logic                           last_accept;
    logic                           capture;
    logic                           out_fire;

    // flush wins over a simultaneous element, so the accept condition excludes it
    assign accept      = (state == FILL) && in_valid && !flush;
    assign last_accept = accept && (count == IDX_W'(N - 1));
    assign capture     = (state == WAIT) && (lat_cnt == '0);
    assign out_fire    = (state == RESULT) && out_ready;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic plus handshake/status outputs, all decoded from state alone
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            FILL: begin
                in_ready = 1'b1;
                if (last_accept) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                busy = 1'b1;
                if (lat_cnt == '0) begin
                    state_next = RESULT;
                end
            end
            RESULT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = FILL;
                end
            end
            default: state_next = FILL;
        endcase
    end

    // Weight bank and bias take writes in every state; indices beyond N-1 match no lane
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                w_bank[i] <= '0;
            end
            b_reg <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (w_wr_en && (w_wr_idx == IDX_W'(i))) begin
                    w_bank[i] <= w_wr_data;
                end
            end
            if (b_wr_en) begin
                b_reg <= b_wr_data;
            end
        end
    end

    // Flatten the bank so the snapshot is a single vector copy
    always_comb begin
        w_packed = '0;
        for (int i = 0; i < N; i++) begin
            w_packed[i*DATA_WIDTH +: DATA_WIDTH] = w_bank[i];
        end
    end

    // Lane fill, snapshot at the last accept, latency countdown and result capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count    <= '0;
            lat_cnt  <= '0;
            pe_x     <= '0;
            pe_w     <= '0;
            pe_b     <= '0;
            out_data <= '0;
        end else begin
            if ((state == FILL) && flush) begin
                count <= '0;
            end else if (accept) begin
                for (int i = 0; i < N; i++) begin
                    if (count == IDX_W'(i)) begin
                        pe_x[i*DATA_WIDTH +: DATA_WIDTH] <= in_data;
                    end
                end
                count <= last_accept ? '0 : count + 1'b1;
            end else if (out_fire) begin
                count <= '0;
            end

            if (last_accept) begin
                lat_cnt <= CNT_W'(LATENCY);
                pe_w    <= w_packed;
                pe_b    <= b_reg;
            end else if ((state == WAIT) && (lat_cnt != '0)) begin
                lat_cnt <= lat_cnt - 1'b1;
            end

            if (capture) begin
                out_data <= pe_y;
            end
        end
    end

endmodule
